mul_sequencer_tainttrack: RTL and testbench

MUL_SEQUENCER_TAINTTRACK -- requirements
Module: mul_sequencer_tainttrack

---
 rtl/mul_sequencer_tainttrack_pkg.sv | 28 ++
 rtl/mul_sequencer_tainttrack_taint_en_reg.sv | 42 ++++
 rtl/mul_sequencer_tainttrack.sv | 149 ++++++++++++++
 tb/tb_mul_sequencer_tainttrack.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_tainttrack_pkg.sv
// Shared definitions for the taint-tracking multiplier sequencer: the FSM state
// encoding and the per-bit merge used by every enabled register.
package mul_sequencer_tainttrack_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StHold  = 2'd3
    } state_e;

    // A tainted enable may or may not have fired, so the result is tainted if the
    // old or new value is tainted, or if the two values differ.
    function automatic logic en_taint_bit(
        input logic en,
        input logic en_t,
        input logic q,
        input logic q_t,
        input logic d,
        input logic d_t
    );
        if (en_t) begin
            return q_t | d_t | (q ^ d);
        end
        return en ? d_t : q_t;
    endfunction

endpackage

// File: rtl/mul_sequencer_tainttrack_taint_en_reg.sv
// Enabled data register carrying a shadow taint vector, asynchronously cleared
// by an active-high reset.
module taint_en_reg
    import mul_sequencer_tainttrack_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             en_t_i,
    input  logic [Width-1:0] d_i,
    input  logic [Width-1:0] d_t_i,
    output logic [Width-1:0] q_o,
    output logic [Width-1:0] q_t_o
);

    logic [Width-1:0] q_q, q_d;
    logic [Width-1:0] q_t_q, q_t_d;

    always_comb begin
        q_d   = en_i ? d_i : q_q;
        q_t_d = '0;
        for (int i = 0; i < int'(Width); i++) begin
            q_t_d[i] = en_taint_bit(en_i, en_t_i, q_q[i], q_t_q[i], d_i[i], d_t_i[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q   <= '0;
            q_t_q <= '0;
        end else begin
            q_q   <= q_d;
            q_t_q <= q_t_d;
        end
    end

    assign q_o   = q_q;
    assign q_t_o = q_t_q;

endmodule

// File: rtl/mul_sequencer_tainttrack.sv
// Single-slot sequencer that hands an operand pair to an external multiplier and
// holds the product for the consumer, propagating taint through control and data.
module mul_sequencer_tainttrack
    import mul_sequencer_tainttrack_pkg::*;
#(
    parameter int unsigned WIDTH = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_valid_t,
    output logic               in_ready,
    output logic               in_ready_t,
    input  logic [WIDTH-1:0]   in_multiplier,
    input  logic [WIDTH-1:0]   in_multiplier_t,
    input  logic [WIDTH-1:0]   in_multiplicand,
    input  logic [WIDTH-1:0]   in_multiplicand_t,
    output logic               mul_start,
    output logic               mul_start_t,
    output logic [WIDTH-1:0]   mul_multiplier,
    output logic [WIDTH-1:0]   mul_multiplier_t,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic [WIDTH-1:0]   mul_multiplicand_t,
    input  logic               mul_done,
    input  logic               mul_done_t,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic [2*WIDTH-1:0] mul_product_t,
    output logic               out_valid,
    output logic               out_valid_t,
    input  logic               out_ready,
    input  logic               out_ready_t,
    output logic [2*WIDTH-1:0] out_product,
    output logic [2*WIDTH-1:0] out_product_t
);

    state_e state_q, state_d;
    logic   first_wait_q, first_wait_d;
    logic   state_t_q, state_t_d;
    logic   decision_t;
    logic   cap_en, cap_en_t;
    logic   prod_en, prod_en_t;

    always_comb begin
        state_d      = state_q;
        first_wait_d = first_wait_q;
        decision_t   = 1'b0;
        cap_en       = 1'b0;
        prod_en      = 1'b0;
        in_ready     = 1'b0;
        mul_start    = 1'b0;
        out_valid    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready   = 1'b1;
                decision_t = in_valid_t;
                if (in_valid) begin
                    cap_en  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                mul_start    = 1'b1;
                first_wait_d = 1'b1;
                state_d      = StWait;
            end
            StWait: begin
                // The first WAIT cycle may still see done from the previous operation.
                if (first_wait_q) begin
                    first_wait_d = 1'b0;
                end else begin
                    decision_t = mul_done_t;
                    if (mul_done) begin
                        prod_en = 1'b1;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                out_valid  = 1'b1;
                decision_t = out_ready_t;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        state_t_d = (state_d == StIdle) ? decision_t : (state_t_q | decision_t);
    end

    // Enable taint only matters where the tainted input actually decides the enable.
    assign cap_en_t  = (state_q == StIdle) & in_valid_t;
    assign prod_en_t = (state_q == StWait) & ~first_wait_q & mul_done_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            first_wait_q <= 1'b0;
            state_t_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_wait_q <= first_wait_d;
            state_t_q    <= state_t_d;
        end
    end

    assign in_ready_t  = state_t_q;
    assign mul_start_t = state_t_q;
    assign out_valid_t = state_t_q;

    taint_en_reg #(
        .Width (WIDTH)
    ) u_multiplier_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (cap_en),
        .en_t_i (cap_en_t),
        .d_i    (in_multiplier),
        .d_t_i  (in_multiplier_t),
        .q_o    (mul_multiplier),
        .q_t_o  (mul_multiplier_t)
    );

    taint_en_reg #(
        .Width (WIDTH)
    ) u_multiplicand_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (cap_en),
        .en_t_i (cap_en_t),
        .d_i    (in_multiplicand),
        .d_t_i  (in_multiplicand_t),
        .q_o    (mul_multiplicand),
        .q_t_o  (mul_multiplicand_t)
    );

    taint_en_reg #(
        .Width (2 * WIDTH)
    ) u_product_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (prod_en),
        .en_t_i (prod_en_t),
        .d_i    (mul_product),
        .d_t_i  (mul_product_t),
        .q_o    (out_product),
        .q_t_o  (out_product_t)
    );

endmodule

// File: tb/tb_mul_sequencer_tainttrack.sv
// Scoreboard bench for the taint-tracking multiplier sequencer with a behavioural
// downstream multiplier and a randomly stalling consumer.
module tb_mul_sequencer_tainttrack;

    localparam int unsigned W  = 8;
    localparam int unsigned W2 = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_valid_t, in_ready, in_ready_t;
    logic [W-1:0]  in_multiplier, in_multiplier_t, in_multiplicand, in_multiplicand_t;
    logic          mul_start, mul_start_t;
    logic [W-1:0]  mul_multiplier, mul_multiplier_t, mul_multiplicand, mul_multiplicand_t;
    logic          mul_done, mul_done_t;
    logic [W2-1:0] mul_product, mul_product_t;
    logic          out_valid, out_valid_t, out_ready, out_ready_t;
    logic [W2-1:0] out_product, out_product_t;

    typedef struct packed {
        logic [W-1:0] a, b, a_t, b_t;
        logic         vt;
    } start_exp_t;

    typedef struct packed {
        logic [W2-1:0] p, p_t;
    } out_exp_t;

    typedef struct packed {
        logic [W2-1:0] p_t;
        logic [7:0]    lat;
        logic          stale;
    } mdl_cmd_t;

    start_exp_t startq[$];
    out_exp_t   outq[$];
    mdl_cmd_t   mq[$];

    int checks = 0, passes = 0;
    int n_cap = 0, n_done = 0, n_abort = 0, n_starts = 0;
    int hold_req = 0;
    int abort_gen = 0;
    logic         cur_vt = 1'b0;
    logic [W-1:0] ra = '0, rb = '0, ra_t = '0, rb_t = '0;

    mul_sequencer_tainttrack #(
        .WIDTH (W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_valid_t         (in_valid_t),
        .in_ready           (in_ready),
        .in_ready_t         (in_ready_t),
        .in_multiplier      (in_multiplier),
        .in_multiplier_t    (in_multiplier_t),
        .in_multiplicand    (in_multiplicand),
        .in_multiplicand_t  (in_multiplicand_t),
        .mul_start          (mul_start),
        .mul_start_t        (mul_start_t),
        .mul_multiplier     (mul_multiplier),
        .mul_multiplier_t   (mul_multiplier_t),
        .mul_multiplicand   (mul_multiplicand),
        .mul_multiplicand_t (mul_multiplicand_t),
        .mul_done           (mul_done),
        .mul_done_t         (mul_done_t),
        .mul_product        (mul_product),
        .mul_product_t      (mul_product_t),
        .out_valid          (out_valid),
        .out_valid_t        (out_valid_t),
        .out_ready          (out_ready),
        .out_ready_t        (out_ready_t),
        .out_product        (out_product),
        .out_product_t      (out_product_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    // Expected results come from the operand values and the taint rules alone.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] at, input logic [W-1:0] bt, input logic vt,
                         input logic [W2-1:0] pt, input int lat, input logic stale);
        start_exp_t s;
        out_exp_t   o;
        mdl_cmd_t   c;
        int         g;
        s.a   = a;
        s.b   = b;
        s.vt  = vt;
        s.a_t = vt ? (ra_t | at | (ra ^ a)) : at;
        s.b_t = vt ? (rb_t | bt | (rb ^ b)) : bt;
        ra = a; rb = b; ra_t = s.a_t; rb_t = s.b_t;
        o.p   = W2'(a) * W2'(b);
        o.p_t = pt;
        c.p_t   = pt;
        c.lat   = 8'(lat);
        c.stale = stale;
        startq.push_back(s);
        outq.push_back(o);
        mq.push_back(c);
        @(negedge clk);
        in_valid = 1'b1; in_valid_t = vt;
        in_multiplier = a; in_multiplier_t = at;
        in_multiplicand = b; in_multiplicand_t = bt;
        g = 0;
        while (!in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            $display("FAIL capture_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, g);
            checks++;
            finish_run();
        end
        @(posedge clk);
        #1;
        n_cap++;
        in_valid = 1'b0; in_valid_t = 1'b0;
        in_multiplier = W'($urandom); in_multiplier_t = W'($urandom);
        in_multiplicand = W'($urandom); in_multiplicand_t = W'($urandom);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((outq.size() != 0 || !in_ready) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) begin
            $display("FAIL idle_timeout: %0d results outstanding, required 0", outq.size());
            checks++;
            finish_run();
        end
    endtask

    // Downstream multiplier: optional stale done in the first WAIT cycle, then done
    // with the true product after the requested latency.
    initial begin
        mdl_cmd_t c;
        int       gen;
        mul_done = 1'b0; mul_done_t = 1'b0; mul_product = '0; mul_product_t = '0;
        forever begin
            @(negedge clk);
            if (mul_start && mq.size() > 0) begin
                c   = mq.pop_front();
                gen = abort_gen;
                @(negedge clk);
                mul_done = c.stale;
                mul_product = W2'($urandom); mul_product_t = W2'($urandom);
                for (int i = 0; i < int'(c.lat); i++) begin
                    @(negedge clk);
                    mul_done = 1'b0;
                    mul_product = W2'($urandom); mul_product_t = W2'($urandom);
                    if (gen != abort_gen) break;
                end
                if (gen == abort_gen) begin
                    @(negedge clk);
                    mul_done = 1'b1;
                    mul_product = W2'(mul_multiplier) * W2'(mul_multiplicand);
                    mul_product_t = c.p_t;
                    @(negedge clk);
                end
                mul_done = 1'b0;
                mul_product = W2'($urandom); mul_product_t = W2'($urandom);
            end
        end
    end

    initial begin
        int hold_cnt = 0;
        out_ready = 1'b0; out_ready_t = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (hold_cnt < hold_req) begin
                    out_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                hold_cnt  = 0;
            end
        end
    end

    // Monitor: samples 1 time unit after the falling edge, after all drivers settle.
    initial begin
        start_exp_t    s;
        out_exp_t      o;
        logic          prev_ov = 1'b0, prev_start = 1'b0;
        logic [W2-1:0] held_p = '0, held_pt = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mul_start) begin
                n_starts++;
                chk("start_single_cycle", 32'(prev_start), 32'd0);
                if (startq.size() == 0) begin
                    chk("start_unexpected", 32'd1, 32'd0);
                end else begin
                    s = startq.pop_front();
                    cur_vt = s.vt;
                    chk("mul_multiplier", 32'(mul_multiplier), 32'(s.a));
                    chk("mul_multiplicand", 32'(mul_multiplicand), 32'(s.b));
                    chk("mul_multiplier_t", 32'(mul_multiplier_t), 32'(s.a_t));
                    chk("mul_multiplicand_t", 32'(mul_multiplicand_t), 32'(s.b_t));
                end
            end
            chk("in_ready", 32'(in_ready), 32'(n_cap == n_done + n_abort));
            if (in_ready) chk("idle_ctrl_taint", 32'({in_ready_t, mul_start_t, out_valid_t}), 32'd0);
            else chk("busy_ctrl_taint", 32'({in_ready_t, mul_start_t, out_valid_t}),
                     32'({3{cur_vt}}));
            if (out_valid) begin
                if (prev_ov) begin
                    chk("hold_product_stable", 32'(out_product), 32'(held_p));
                    chk("hold_taint_stable", 32'(out_product_t), 32'(held_pt));
                end
                held_p  = out_product;
                held_pt = out_product_t;
                if (out_ready) begin
                    n_done++;
                    if (outq.size() == 0) begin
                        chk("result_unexpected", 32'd1, 32'd0);
                    end else begin
                        o = outq.pop_front();
                        chk("out_product", 32'(out_product), 32'(o.p));
                        chk("out_product_t", 32'(out_product_t), 32'(o.p_t));
                    end
                end
            end
            prev_ov    = out_valid;
            prev_start = mul_start;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_ctrl"}, 32'({mul_start, out_valid, in_ready_t, mul_start_t, out_valid_t}), 32'd0);
        chk({tag, "_operands"}, 32'({mul_multiplier, mul_multiplicand}), 32'd0);
        chk({tag, "_operand_t"}, 32'({mul_multiplier_t, mul_multiplicand_t}), 32'd0);
        chk({tag, "_product"}, 32'(out_product), 32'd0);
        chk({tag, "_product_t"}, 32'(out_product_t), 32'd0);
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        in_valid = 1'b0; in_valid_t = 1'b0;
        in_multiplier = '0; in_multiplier_t = '0; in_multiplicand = '0; in_multiplicand_t = '0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Plain 13 x 11 with a long multiplier latency.
        s0 = n_starts;
        issue(8'd13, 8'd11, 8'h00, 8'h00, 1'b0, 16'h0000, 7, 1'b0);
        wait_idle();
        chk("single_start_pulse", 32'(n_starts - s0), 32'd1);

        // Operand and product taint pass straight through with untainted enables.
        issue(8'd200, 8'd77, 8'h00, 8'h01, 1'b0, 16'h00FF, 3, 1'b0);
        wait_idle();

        // Tainted in_valid at capture taints the whole transaction's control.
        issue(8'd5, 8'd9, 8'h00, 8'h00, 1'b1, 16'h0000, 2, 1'b0);
        wait_idle();

        // Stale done in the first WAIT cycle and a five-cycle consumer stall.
        hold_req = 5;
        issue(8'd31, 8'd17, 8'h10, 8'h00, 1'b0, 16'h1234, 1, 1'b1);
        wait_idle();
        hold_req = 0;

        // Reset while waiting on the multiplier abandons the operation.
        issue(8'd9, 8'd7, 8'h00, 8'h00, 1'b0, 16'h0000, 40, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midop_reset");
        abort_gen++;
        n_abort++;
        outq.delete();
        ra = '0; rb = '0; ra_t = '0; rb_t = '0;
        #1;
        rst = 1'b0;
        issue(8'd2, 8'd3, 8'h00, 8'h00, 1'b0, 16'h0000, 0, 1'b0);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            hold_req = $urandom_range(0, 3);
            issue(W'($urandom), W'($urandom),
                  ($urandom_range(0, 1) == 1) ? W'($urandom) : W'(0),
                  ($urandom_range(0, 1) == 1) ? W'($urandom) : W'(0),
                  ($urandom_range(0, 3) == 0), W2'($urandom),
                  $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        chk("start_count", 32'(n_starts), 32'(n_cap));
        finish_run();
    end

endmodule
